voting_tally_ctrl: RTL and testbench
====================================

// Module: voting_tally_ctrl
// PURPOSE
//  Sequential front-end for the yes/no majority-vote datapath.
//  - Opens an election and arbitrates N_VOTERS ballot requesters round-robin, one ballot per cycle.
//  - Enforces one vote per voter and accumulates yes/no tallies.
//  - Closes the election on command or when every voter has voted, then reports the majority with an external tie-break bit.
// PARAMETERS
//  N_VOTERS  15                        number of voter ports (>=2)
//  CNT_W     $clog2(N_VOTERS+1)        tally width; derived, do not override
// PORTS
//  clk          in   1         clock, all state on rising edge
//  rst_n        in   1         asynchronous active-low reset
//  start_i      in   1         pulse: open new election (IDLE or DONE only)
//  close_i      in   1         pulse: close election early (COLLECT only)
//  tie_break_i  in   1         result when yes==no; sampled in DECIDE
//  vote_req_i   in   N_VOTERS  per-voter ballot request, held until granted
//  vote_val_i   in   N_VOTERS  per-voter ballot: 1=yes 0=no, stable while req
//  vote_gnt_o   out  N_VOTERS  one-hot/zero grant, combinational from req+state
//  dup_o        out  1         pulse: a voter that already voted is requesting
//  busy_o       out  1         high in COLLECT and DECIDE
//  done_o       out  1         high in DONE; result/tallies valid
//  result_o     out  1         1 = motion carried
//  yes_cnt_o    out  CNT_W     yes tally
//  no_cnt_o     out  CNT_W     no tally
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, voted mask=0, RR pointer=0.
//    All outputs are 0, including the tallies and result_o.
//  FSM states: IDLE, COLLECT, DECIDE, DONE.
//  IDLE/DONE --start_i--> COLLECT. On the same edge, clear tallies, voted mask and result.
//  COLLECT:
//    - eligible = vote_req_i & ~voted.
//    - Grant the first eligible index at or after the pointer, wrapping N_VOTERS-1 -> 0.
//    - On the grant edge: voted[g]<=1; yes_cnt++ if vote_val_i[g], else no_cnt++; pointer<=g+1 (wrapping).
//    - No eligible voter -> no grant; pointer unchanged.
//    - Requester sees gnt in the same cycle and must drop req next cycle.
//    - dup_o (registered) = |(vote_req_i & voted), asserted one cycle after the offending cycle.
//  COLLECT -> DECIDE when close_i=1, or when the voted mask becomes all-ones after this cycle's update.
//    A grant in the same cycle as close_i is counted.
//  DECIDE (exactly 1 cycle): result <= (yes>no) | ((yes==no) & tie_break_i). No grants. -> DONE.
//  DONE: done_o=1. result and tallies hold until the next start_i.
//  Latency: last grant in cycle t -> DECIDE at t+1 -> done_o high at t+2.
//  Ignored inputs: start_i in COLLECT/DECIDE; close_i outside COLLECT.
//    vote_req_i is never granted outside COLLECT.
//  Width rule: each voter is counted at most once, so yes+no <= N_VOTERS. Tallies cannot overflow CNT_W.
//  Zero-vote close: yes=no=0, so result_o = tie_break_i.
// STRUCTURE
//  voting_pkg:
//    - state enum typedef vt_state_e {IDLE, COLLECT, DECIDE, DONE};
//    - function cnt_w(n) returning $clog2(n+1).
//  Sub-module rr_arbiter #(N): inputs req, ptr; outputs one-hot gnt and gnt index.
//    Purely combinational; the pointer register lives in voting_tally_ctrl.
//  Top holds the FSM, voted mask, pointer, tally counters, result register and dup_o flop.
// TESTING
//  1 Reset mid-COLLECT after 3 grants -> next cycle all outputs 0, state IDLE, pointer 0.
//  2 start; all 15 req simultaneous, vals 8 yes/7 no:
//    - grants 0,1,..,14 on consecutive cycles;
//    - done_o 2 cycles after grant 14;
//    - yes=8, no=7, result_o=1.
//  3 start; voters 2,5 vote yes, voters 3,9 vote no, close_i:
//    - tie_break_i=0 -> result_o=0;
//    - repeat with tie_break_i=1 -> result_o=1.
//  4 Pointer at 14, req on 0 and 14 -> grant 14, then grant 0 (wrap).
//    Voter 14 re-requests -> no grant, dup_o=1 one cycle later.
//  5 close_i in the same cycle as a grant to voter 4 (yes) -> vote counted, yes_cnt_o includes it.
//  6 start_i during COLLECT ignored; start_i in DONE -> tallies cleared, new election.
//    close_i immediately after start -> yes=no=0, result_o=tie_break_i.

Source files
------------

// File: rtl/voting_pkg.sv
// Shared types and helpers for the yes/no voting front-end.
package voting_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DECIDE,
        DONE
    } vt_state_e;

    // Tally width that can hold every voter voting the same way.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. It picks the first requester at or after
// ptr_i and wraps from N-1 to 0. The pointer register belongs to the caller.
module rr_arbiter #(
    parameter int unsigned N  = 15,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    // Scan N slots starting at the pointer and keep the first hit.
    always_comb begin
        int unsigned k;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(ptr_i) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!valid_o && req_i[IW'(k)]) begin
                valid_o         = 1'b1;
                gnt_o[IW'(k)]   = 1'b1;
                idx_o           = IW'(k);
            end
        end
    end

endmodule

// File: rtl/voting_tally_ctrl.sv
// Election controller. It opens an election, grants one ballot per cycle
// round-robin, allows one vote per voter and tallies yes/no. It closes on
// command or once everyone has voted, then registers the majority result.
module voting_tally_ctrl
    import voting_pkg::*;
#(
    parameter int unsigned N_VOTERS = 15,
    parameter int unsigned CNT_W    = cnt_w(N_VOTERS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                close_i,
    input  logic                tie_break_i,
    input  logic [N_VOTERS-1:0] vote_req_i,
    input  logic [N_VOTERS-1:0] vote_val_i,
    output logic [N_VOTERS-1:0] vote_gnt_o,
    output logic                dup_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                result_o,
    output logic [CNT_W-1:0]    yes_cnt_o,
    output logic [CNT_W-1:0]    no_cnt_o
);

    localparam int unsigned      IDX_W    = $clog2(N_VOTERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOTERS - 1);

    vt_state_e            state_q;
    logic [N_VOTERS-1:0]  voted_q;
    logic [N_VOTERS-1:0]  voted_d;
    logic [N_VOTERS-1:0]  eligible;
    logic [N_VOTERS-1:0]  arb_gnt;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     ptr_d;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;
    logic                 grant_en;
    logic [CNT_W-1:0]     yes_q;
    logic [CNT_W-1:0]     no_q;
    logic                 result_q;
    logic                 dup_q;

    // Voters that already voted never compete for a grant again.
    assign eligible = vote_req_i & ~voted_q;

    rr_arbiter #(
        .N  (N_VOTERS),
        .IW (IDX_W)
    ) u_arb (
        .req_i   (eligible),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Grant qualification, post-grant voted mask and the next pointer.
    always_comb begin
        grant_en = (state_q == COLLECT) && arb_valid;
        voted_d  = voted_q | (grant_en ? arb_gnt : '0);
        ptr_d    = ptr_q;
        if (grant_en) begin
            ptr_d = (arb_idx == LAST_IDX) ? '0 : arb_idx + IDX_W'(1);
        end
    end

    // Election FSM together with the voted mask, pointer, tallies, result and dup flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            voted_q  <= '0;
            ptr_q    <= '0;
            yes_q    <= '0;
            no_q     <= '0;
            result_q <= 1'b0;
            dup_q    <= 1'b0;
        end else begin
            dup_q <= (state_q == COLLECT) && |(vote_req_i & voted_q);
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q  <= COLLECT;
                        voted_q  <= '0;
                        yes_q    <= '0;
                        no_q     <= '0;
                        result_q <= 1'b0;
                    end
                end
                COLLECT: begin
                    voted_q <= voted_d;
                    ptr_q   <= ptr_d;
                    if (grant_en) begin
                        if (vote_val_i[arb_idx]) begin
                            yes_q <= yes_q + CNT_W'(1);
                        end else begin
                            no_q <= no_q + CNT_W'(1);
                        end
                    end
                    // A grant in the closing cycle still lands in the tallies above.
                    if (close_i || (&voted_d)) begin
                        state_q <= DECIDE;
                    end
                end
                DECIDE: begin
                    result_q <= (yes_q > no_q) | ((yes_q == no_q) & tie_break_i);
                    state_q  <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vote_gnt_o = grant_en ? arb_gnt : '0;
    assign dup_o      = dup_q;
    assign busy_o     = (state_q == COLLECT) || (state_q == DECIDE);
    assign done_o     = (state_q == DONE);
    assign result_o   = result_q;
    assign yes_cnt_o  = yes_q;
    assign no_cnt_o   = no_q;

endmodule

// File: tb/tb_voting_tally_ctrl.sv
// Scoreboard bench for voting_tally_ctrl. The stimulus queues the expected
// grants, dup pulses and results. A negedge monitor pops and compares them.
module tb_voting_tally_ctrl;

    localparam int N = 15;

    typedef struct {
        logic [3:0] yes;
        logic [3:0] no;
        logic       res;
        bit         lat;
    } res_t;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic          close_i;
    logic          tie_break_i;
    logic [N-1:0]  vote_req_i;
    logic [N-1:0]  vote_val_i;
    logic [N-1:0]  vote_gnt_o;
    logic          dup_o;
    logic          busy_o;
    logic          done_o;
    logic          result_o;
    logic [3:0]    yes_cnt_o;
    logic [3:0]    no_cnt_o;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    int            last_gnt_cyc = 0;
    logic          done_prev = 1'b0;

    logic [N-1:0]  gnt_exp[$];
    res_t          res_exp[$];
    int            dup_exp[$];
    res_t          e;
    logic [N-1:0]  ge;
    int            de;

    voting_tally_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .close_i     (close_i),
        .tie_break_i (tie_break_i),
        .vote_req_i  (vote_req_i),
        .vote_val_i  (vote_val_i),
        .vote_gnt_o  (vote_gnt_o),
        .dup_o       (dup_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .yes_cnt_o   (yes_cnt_o),
        .no_cnt_o    (no_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic push_res(input int y, input int n, input bit r, input bit l);
        res_t t;
        t.yes = 4'(y);
        t.no  = 4'(n);
        t.res = r;
        t.lat = l;
        res_exp.push_back(t);
    endtask

    // One cycle: note the grant, cross the edge, then drop any granted request.
    task automatic tick();
        logic [N-1:0] g;
        @(negedge clk);
        g = vote_gnt_o;
        @(posedge clk);
        #1;
        vote_req_i = vote_req_i & ~g;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic do_close();
        close_i = 1'b1;
        tick();
        close_i = 1'b0;
    endtask

    task automatic wait_req_clear(input int budget);
        int n = 0;
        while (vote_req_i != '0 && n < budget) begin
            tick();
            n++;
        end
        chk("req_served", 32'(vote_req_i), 32'd0);
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (!done_o && n < budget) begin
            tick();
            n++;
        end
        chk("done_reached", 32'(done_o), 32'd1);
    endtask

    // Monitor: compare every grant, dup pulse and completed election.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            done_prev = 1'b0;
        end else begin
            if (vote_gnt_o != '0) begin
                if (gnt_exp.size() == 0) begin
                    chk("unexpected_gnt", 32'(vote_gnt_o), 32'd0);
                end else begin
                    ge = gnt_exp.pop_front();
                    chk("gnt", 32'(vote_gnt_o), 32'(ge));
                end
                last_gnt_cyc = cyc;
            end
            if (dup_o) begin
                if (dup_exp.size() == 0) begin
                    chk("unexpected_dup", 32'(dup_o), 32'd0);
                end else begin
                    de = dup_exp.pop_front();
                    chk("dup_cycle", 32'(cyc), 32'(de));
                end
            end
            if (done_o && !done_prev) begin
                if (res_exp.size() == 0) begin
                    chk("unexpected_done", 32'(done_o), 32'd0);
                end else begin
                    e = res_exp.pop_front();
                    chk("yes_cnt", 32'(yes_cnt_o), 32'(e.yes));
                    chk("no_cnt", 32'(no_cnt_o), 32'(e.no));
                    chk("result", 32'(result_o), 32'(e.res));
                    if (e.lat) chk("done_latency", 32'(cyc - last_gnt_cyc), 32'd2);
                end
            end
            done_prev = done_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        start_i     = 1'b0;
        close_i     = 1'b0;
        tie_break_i = 1'b0;
        vote_req_i  = '0;
        vote_val_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_result", 32'(result_o), 32'd0);
        chk("rst_yes", 32'(yes_cnt_o), 32'd0);
        chk("rst_dup", 32'(dup_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: three grants, then an asynchronous reset mid-COLLECT.
        vote_val_i = 15'h0005;
        vote_req_i = 15'h0007;
        gnt_exp.push_back(15'h0001);
        gnt_exp.push_back(15'h0002);
        gnt_exp.push_back(15'h0004);
        do_start();
        wait_req_clear(10);
        chk("t1_yes_before_rst", 32'(yes_cnt_o), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_busy", 32'(busy_o), 32'd0);
        chk("t1_rst_yes", 32'(yes_cnt_o), 32'd0);
        chk("t1_rst_no", 32'(no_cnt_o), 32'd0);
        vote_req_i = 15'h7FFF;
        vote_val_i = 15'h00FF;
        @(posedge clk);
        #1;
        chk("t1_rst_gnt", 32'(vote_gnt_o), 32'd0);
        chk("t1_rst_done", 32'(done_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t1_idle_gnt", 32'(vote_gnt_o), 32'd0);
        chk("t1_idle_busy", 32'(busy_o), 32'd0);

        // 2: all voters at once, 8 yes / 7 no, grants 0..14 from a reset pointer.
        for (int i = 0; i < N; i++) gnt_exp.push_back(N'(1) << i);
        push_res(8, 7, 1'b1, 1'b1);
        do_start();
        run_until_done(40);

        // 3: two yes, two no, closed early; tie-break decides.
        for (int pass = 0; pass < 2; pass++) begin
            tie_break_i = pass[0];
            vote_val_i  = 15'h0024;
            vote_req_i  = 15'h022C;
            gnt_exp.push_back(15'h0004);
            gnt_exp.push_back(15'h0008);
            gnt_exp.push_back(15'h0020);
            gnt_exp.push_back(15'h0200);
            push_res(2, 2, pass[0], 1'b0);
            do_start();
            wait_req_clear(20);
            do_close();
            run_until_done(10);
        end

        // 4: walk the pointer to 14, check the wrap, then a duplicate request.
        vote_val_i = '0;
        vote_req_i = 15'h2000;
        gnt_exp.push_back(15'h2000);
        do_start();
        wait_req_clear(10);
        vote_req_i = 15'h4001;
        gnt_exp.push_back(15'h4000);
        gnt_exp.push_back(15'h0001);
        wait_req_clear(10);
        vote_req_i = 15'h4000;
        dup_exp.push_back(cyc + 2);
        tick();
        vote_req_i = '0;
        tick();
        push_res(0, 3, 1'b0, 1'b0);
        do_close();
        run_until_done(10);

        // 5: grant to voter 4 in the same cycle as close.
        do_start();
        vote_val_i = 15'h0010;
        vote_req_i = 15'h0010;
        close_i    = 1'b1;
        gnt_exp.push_back(15'h0010);
        push_res(1, 0, 1'b1, 1'b1);
        tick();
        close_i = 1'b0;
        run_until_done(10);

        // 6: start ignored mid-election; restart from DONE; zero-vote closes.
        vote_val_i = 15'h0002;
        vote_req_i = 15'h0002;
        gnt_exp.push_back(15'h0002);
        do_start();
        wait_req_clear(10);
        do_start();
        chk("t6_start_ign_busy", 32'(busy_o), 32'd1);
        chk("t6_start_ign_yes", 32'(yes_cnt_o), 32'd1);
        push_res(1, 0, 1'b1, 1'b0);
        do_close();
        run_until_done(10);
        do_close();
        chk("t6_close_ign_done", 32'(done_o), 32'd1);
        chk("t6_close_ign_yes", 32'(yes_cnt_o), 32'd1);
        do_start();
        chk("t6_restart_busy", 32'(busy_o), 32'd1);
        chk("t6_restart_yes", 32'(yes_cnt_o), 32'd0);
        chk("t6_restart_result", 32'(result_o), 32'd0);
        tie_break_i = 1'b1;
        push_res(0, 0, 1'b1, 1'b0);
        do_close();
        run_until_done(10);
        tie_break_i = 1'b0;
        push_res(0, 0, 1'b0, 1'b0);
        do_start();
        do_close();
        run_until_done(10);

        repeat (3) tick();
        chk("gnt_queue_empty", 32'(gnt_exp.size()), 32'd0);
        chk("res_queue_empty", 32'(res_exp.size()), 32'd0);
        chk("dup_queue_empty", 32'(dup_exp.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
